// File: rtl/pcs_pkg.sv
// Shared constants for the PCS block-lock controller: sync header codes,
// lock FSM state encoding and default parameter values.
package pcs_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam logic [1:0] ST_HUNT      = 2'd0;
    localparam logic [1:0] ST_SLIP_WAIT = 2'd1;
    localparam logic [1:0] ST_LOCKED    = 2'd2;

    localparam int PCS_DATA_WIDTH_DEF   = 66;
    localparam int SH_CNT_MAX_DEF       = 64;
    localparam int SH_INVALID_MAX_DEF   = 16;
    localparam int SLIP_WAIT_CYCLES_DEF = 4;
    localparam int BER_WINDOW_DEF       = 19531;
    localparam int BER_CNT_MAX_DEF      = 16;

    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/pcs_ber_monitor.sv
// High-BER monitor: counts invalid sync headers per window of valid blocks
// while locked and raises hi_ber when the per-window count hits its limit.
module pcs_ber_monitor
    import pcs_pkg::*;
#(
    parameter int BER_WINDOW  = BER_WINDOW_DEF,
    parameter int BER_CNT_MAX = BER_CNT_MAX_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_locked,
    input  logic i_valid,
    input  logic i_sh_invalid,
    output logic o_hi_ber
);

    localparam int WINW = $clog2(BER_WINDOW + 1);
    localparam int ERRW = $clog2(BER_CNT_MAX + 1);
    localparam logic [WINW-1:0] WIN_LAST = WINW'(BER_WINDOW - 1);
    localparam logic [ERRW-1:0] ERR_MAX  = ERRW'(BER_CNT_MAX);

    logic [WINW-1:0] r_win_cnt;
    logic [ERRW-1:0] r_err_cnt;
    logic            r_hi_ber;
    logic [ERRW-1:0] w_err_nxt;
    logic            w_hit;

    always_comb begin
        w_err_nxt = r_err_cnt;
        if (i_sh_invalid && (r_err_cnt != ERR_MAX))
            w_err_nxt = r_err_cnt + 1'b1;
    end

    assign w_hit = (w_err_nxt == ERR_MAX);

    // Window is a down-counter of valid blocks; at terminal count the flag
    // follows whether this window reached the limit.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_locked) begin
            r_win_cnt <= WIN_LAST;
            r_err_cnt <= '0;
            r_hi_ber  <= 1'b0;
        end else if (i_valid) begin
            if (r_win_cnt == '0) begin
                r_win_cnt <= WIN_LAST;
                r_err_cnt <= '0;
                r_hi_ber  <= w_hit;
            end else begin
                r_win_cnt <= r_win_cnt - 1'b1;
                r_err_cnt <= w_err_nxt;
                if (w_hit)
                    r_hi_ber <= 1'b1;
            end
        end
    end

    assign o_hi_ber = r_hi_ber;

endmodule

// File: rtl/pcs_block_lock_ctrl.sv
// Block-lock controller ahead of the 64b/66b decoder: sync-header lock FSM,
// gearbox slip generation and a one-cycle forwarding stage.
// Optional high-BER monitor enabled by defining PCS_BER_MON_EN.
module pcs_block_lock_ctrl
    import pcs_pkg::*;
#(
    parameter int PCS_DATA_WIDTH   = PCS_DATA_WIDTH_DEF,
    parameter int SH_CNT_MAX       = SH_CNT_MAX_DEF,
    parameter int SH_INVALID_MAX   = SH_INVALID_MAX_DEF,
`ifdef PCS_BER_MON_EN
    parameter int BER_WINDOW       = BER_WINDOW_DEF,
    parameter int BER_CNT_MAX      = BER_CNT_MAX_DEF,
`endif
    parameter int SLIP_WAIT_CYCLES = SLIP_WAIT_CYCLES_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [PCS_DATA_WIDTH-1:0] i_rx_data_in,
    input  logic                      i_rx_valid_in,
    output logic                      o_slip_out,
    output logic [PCS_DATA_WIDTH-1:0] o_dec_data_out,
    output logic                      o_dec_valid_out,
    output logic                      o_block_lock,
    output logic                      o_hi_ber,
    output logic [15:0]               o_sh_err_count
);

    localparam int CNTW  = $clog2(SH_CNT_MAX + 1);
    localparam int INVW  = $clog2(SH_INVALID_MAX + 1);
    localparam int WAITW = $clog2(SLIP_WAIT_CYCLES + 1);
    localparam logic [CNTW-1:0]  CNT_LAST  = CNTW'(SH_CNT_MAX - 1);
    localparam logic [INVW-1:0]  INV_LAST  = INVW'(SH_INVALID_MAX - 1);
    localparam logic [WAITW-1:0] WAIT_LAST = WAITW'(SLIP_WAIT_CYCLES - 1);

    logic [1:0]                r_state;
    logic [CNTW-1:0]           r_sh_cnt;
    logic [INVW-1:0]           r_sh_inv;
    logic [WAITW-1:0]          r_wait_cnt;
    logic                      r_slip;
    logic                      r_block_lock;
    logic [PCS_DATA_WIDTH-1:0] r_dec_data;
    logic                      r_dec_valid;
    logic [15:0]               r_sh_err_count;
    logic                      w_sh_ok;
    logic                      w_hi_ber;

    assign w_sh_ok = sh_is_valid(i_rx_data_in[PCS_DATA_WIDTH-1 -: 2]);

`ifdef PCS_BER_MON_EN
    pcs_ber_monitor #(
        .BER_WINDOW  (BER_WINDOW),
        .BER_CNT_MAX (BER_CNT_MAX)
    ) u_ber_monitor (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_locked     (r_state == ST_LOCKED),
        .i_valid      (i_rx_valid_in),
        .i_sh_invalid (~w_sh_ok),
        .o_hi_ber     (w_hi_ber)
    );
`else
    assign w_hi_ber = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_HUNT;
            r_sh_cnt       <= '0;
            r_sh_inv       <= '0;
            r_wait_cnt     <= '0;
            r_slip         <= 1'b0;
            r_block_lock   <= 1'b0;
            r_dec_data     <= '0;
            r_dec_valid    <= 1'b0;
            r_sh_err_count <= '0;
        end else begin
            r_slip      <= 1'b0;
            r_dec_valid <= i_rx_valid_in & r_block_lock & ~w_hi_ber;
            if (i_rx_valid_in)
                r_dec_data <= i_rx_data_in;

            case (r_state)
                ST_HUNT: begin
                    if (i_rx_valid_in) begin
                        if (!w_sh_ok) begin
                            r_slip     <= 1'b1;
                            r_sh_cnt   <= '0;
                            r_sh_inv   <= '0;
                            r_wait_cnt <= WAIT_LAST;
                            r_state    <= ST_SLIP_WAIT;
                        end else if (r_sh_cnt == CNT_LAST) begin
                            r_sh_cnt     <= '0;
                            r_sh_inv     <= '0;
                            r_block_lock <= 1'b1;
                            r_state      <= ST_LOCKED;
                        end else begin
                            r_sh_cnt <= r_sh_cnt + 1'b1;
                        end
                    end
                end
                ST_SLIP_WAIT: begin
                    if (r_wait_cnt == '0)
                        r_state <= ST_HUNT;
                    else
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                end
                ST_LOCKED: begin
                    if (i_rx_valid_in) begin
                        if (!w_sh_ok && (r_sh_err_count != 16'hFFFF))
                            r_sh_err_count <= r_sh_err_count + 16'd1;
                        // Loss of lock takes priority over a coincident window end.
                        if (!w_sh_ok && (r_sh_inv == INV_LAST)) begin
                            r_block_lock <= 1'b0;
                            r_slip       <= 1'b1;
                            r_sh_cnt     <= '0;
                            r_sh_inv     <= '0;
                            r_wait_cnt   <= WAIT_LAST;
                            r_state      <= ST_SLIP_WAIT;
                        end else if (r_sh_cnt == CNT_LAST) begin
                            r_sh_cnt <= '0;
                            r_sh_inv <= '0;
                        end else begin
                            r_sh_cnt <= r_sh_cnt + 1'b1;
                            if (!w_sh_ok)
                                r_sh_inv <= r_sh_inv + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

    assign o_slip_out      = r_slip;
    assign o_dec_data_out  = r_dec_data;
    assign o_dec_valid_out = r_dec_valid;
    assign o_block_lock    = r_block_lock;
    assign o_hi_ber        = w_hi_ber;
    assign o_sh_err_count  = r_sh_err_count;

endmodule

// File: tb/tb_pcs_block_lock_ctrl.sv
// Directed bench for pcs_block_lock_ctrl: acquisition, slip in HUNT, window
// maintenance, loss of lock, reset while locked and (with PCS_BER_MON_EN) hi_ber.
module tb_pcs_block_lock_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [65:0] rx_data;
    logic        rx_valid;
    logic        slip;
    logic [65:0] dec_data;
    logic        dec_valid;
    logic        block_lock;
    logic        hi_ber;
    logic [15:0] sh_err_count;

    int total = 0;
    int bad   = 0;
    logic [31:0] seq = 32'h0;
    logic [65:0] last_data;

    always #5 clk = ~clk;

    pcs_block_lock_ctrl #(
`ifdef PCS_BER_MON_EN
        .BER_WINDOW (128),
`endif
        .PCS_DATA_WIDTH (66)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_rx_data_in    (rx_data),
        .i_rx_valid_in   (rx_valid),
        .o_slip_out      (slip),
        .o_dec_data_out  (dec_data),
        .o_dec_valid_out (dec_valid),
        .o_block_lock    (block_lock),
        .o_hi_ber        (hi_ber),
        .o_sh_err_count  (sh_err_count)
    );

    typedef struct {
        logic       v;
        logic [1:0] sh;
        logic       slip;
        logic       lock;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Drive one block, clock it, and return 1 time unit after the edge.
    task automatic send(input logic v, input logic [1:0] sh);
        seq      = seq + 32'd1;
        rx_valid = v;
        rx_data  = {sh, 32'hbbaa5544, seq};
        if (v)
            last_data = rx_data;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic v, input logic [1:0] sh, input logic s, input logic l);
        vec_t e;
        e.v = v; e.sh = sh; e.slip = s; e.lock = l;
        vecs.push_back(e);
    endfunction

    initial begin
        // HUNT slip at valid #10 with gaps, 4 ignored cycles, then a full re-acquire.
        for (int i = 0; i < 9; i++) begin
            add(1'b1, 2'b01, 1'b0, 1'b0);
            if (i == 3) begin
                add(1'b0, 2'b11, 1'b0, 1'b0);
                add(1'b0, 2'b00, 1'b0, 1'b0);
            end
        end
        add(1'b1, 2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            add(1'b1, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            if (i == 20 || i == 40)
                add(1'b0, 2'b11, 1'b0, 1'b0);
            add(1'b1, (i % 2 == 0) ? 2'b10 : 2'b01, 1'b0, (i == 63));
        end

        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; last_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_slip", slip, 0);
        check("rst_lock", block_lock, 0);
        check("rst_dvalid", dec_valid, 0);
        check("rst_ddata", dec_data, 0);
        check("rst_hiber", hi_ber, 0);
        check("rst_errcnt", sh_err_count, 0);
        rst = 1'b0;

        // Acquire from reset: lock after the 64th valid header.
        for (int i = 0; i < 64; i++) begin
            send(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("acq_lock", block_lock, (i == 63));
            check("acq_dvalid", dec_valid, 0);
            check("acq_slip", slip, 0);
        end

        // Three windows with 15 invalid each (tail, head, tail): lock held.
        for (int w = 0; w < 3; w++) begin
            for (int j = 0; j < 64; j++) begin
                logic badh;
                badh = (w == 1) ? (j < 15) : (j >= 49);
                if (w == 0 && j == 10) begin
                    send(1'b0, 2'b00);
                    check("gap_lock", block_lock, 1);
                end
                send(1'b1, badh ? 2'b11 : 2'b01);
                if (w == 0 && j == 0) begin
                    check("first_dvalid", dec_valid, 1);
                    check("first_ddata", dec_data, last_data);
                end
                check("win_lock", block_lock, 1);
                check("win_slip", slip, 0);
            end
        end
        check("win_errcnt", sh_err_count, 45);

        // Reset while locked.
        rst = 1'b1;
        send(1'b1, 2'b01);
        check("mid_rst_lock", block_lock, 0);
        check("mid_rst_dvalid", dec_valid, 0);
        check("mid_rst_ddata", dec_data, 0);
        check("mid_rst_errcnt", sh_err_count, 0);
        check("mid_rst_hiber", hi_ber, 0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            send(vecs[k].v, vecs[k].sh);
            check($sformatf("vec%0d_slip", k), slip, vecs[k].slip);
            check($sformatf("vec%0d_lock", k), block_lock, vecs[k].lock);
            check($sformatf("vec%0d_dvalid", k), dec_valid, 0);
        end

        // Loss of lock on the 16th invalid header within one window.
        for (int j = 0; j < 32; j++) begin
            send(1'b1, (j % 2 == 1) ? 2'b00 : 2'b10);
            check("loss_lock", block_lock, (j != 31));
            check("loss_slip", slip, (j == 31));
        end
        check("loss_dvalid", dec_valid, 1);
        check("loss_errcnt", sh_err_count, 16);
        send(1'b1, 2'b01);
        check("post_loss_slip", slip, 0);
        check("post_loss_dvalid", dec_valid, 0);
        check("post_loss_lock", block_lock, 0);

        // Finish the slip wait and relock.
        for (int i = 0; i < 3; i++)
            send(1'b1, 2'b11);
        for (int i = 0; i < 64; i++)
            send(1'b1, 2'b01);
        check("relock", block_lock, 1);
        check("relock_slip", slip, 0);

`ifdef PCS_BER_MON_EN
        for (int j = 0; j < 128; j++) begin
            send(1'b1, (j % 8 == 0) ? 2'b11 : 2'b01);
            if (j == 119) check("ber_before", hi_ber, 0);
            if (j == 120) check("ber_set", hi_ber, 1);
            if (j == 121) check("ber_dvalid", dec_valid, 0);
        end
        check("ber_win1_end", hi_ber, 1);
        for (int j = 0; j < 128; j++) begin
            send(1'b1, 2'b10);
            if (j == 126) check("ber_hold", hi_ber, 1);
        end
        check("ber_clear", hi_ber, 0);
        send(1'b1, 2'b01);
        check("ber_dvalid_back", dec_valid, 1);
        check("ber_lock", block_lock, 1);
`else
        send(1'b1, 2'b00);
        check("nober_hiber", hi_ber, 0);
        check("nober_dvalid", dec_valid, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
